// File: rtl/uart_rx_frame.sv
// 8N1 UART byte receiver feeding a "<bank payload>" frame parser.
// A completed frame updates data_out/bank and pulses data_write_copy once.
//
// rx state  | meaning
// RX_IDLE   | line idle, waiting for a falling edge
// RX_START  | half-bit wait, confirm start bit is still low
// RX_DATA   | sample 8 data bits at bit centres, LSB first
// RX_STOP   | sample stop bit; high delivers byte, low is a framing error
//
// frame st   | meaning
// P_WAIT_SOF | hunting for '<'
// P_GET_BANK | next byte (minus '0') is the pending bank
// P_GET_DATA | shifting payload bytes until '>'
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 54
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rxd,
  output logic [255:0] data_out,
  output logic         data_write_copy,
  output logic [7:0]   bank
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SOF = 8'h3C;
  localparam logic [7:0] EOF = 8'h3E;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_WAIT_SOF, P_GET_BANK, P_GET_DATA} p_state_t;

  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic            rxd_meta_d, rxd_sync_d, rxd_prev_d;
  rx_state_t       rx_state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shreg_q;
  logic [7:0]      rx_byte_q;
  logic            rx_valid_q;
  logic            rx_ferr_q;
  p_state_t        p_state_q;
  logic [255:0]    pay_q;
  logic [5:0]      cnt_q;
  logic [7:0]      pend_bank_q;
  logic [255:0]    data_out_q;
  logic [7:0]      bank_q;
  logic            strobe_q;

  always_comb begin
    rxd_meta_d = rxd;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
  end

  // Synchronizer plus one delay stage for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rxd_prev_q <= rxd_prev_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rxd_prev_q && !rxd_sync_q) begin
            timer_q    <= HALF_LD;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (!rxd_sync_q) begin
            timer_q    <= BIT_LD;
            bit_cnt_q  <= '0;
            rx_state_q <= RX_DATA;
          end else begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            shreg_q <= {rxd_sync_q, shreg_q[7:1]};
            timer_q <= BIT_LD;
            if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
            else                   bit_cnt_q  <= bit_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            if (rxd_sync_q) begin
              rx_byte_q  <= shreg_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_ferr_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // A framing error aborts whatever frame was open; outputs only move on '>'.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state_q   <= P_WAIT_SOF;
      pay_q       <= '0;
      cnt_q       <= '0;
      pend_bank_q <= '0;
      data_out_q  <= '0;
      bank_q      <= '0;
      strobe_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (rx_ferr_q) begin
        p_state_q <= P_WAIT_SOF;
      end else if (rx_valid_q) begin
        case (p_state_q)
          P_WAIT_SOF: begin
            if (rx_byte_q == SOF) begin
              pay_q     <= '0;
              cnt_q     <= '0;
              p_state_q <= P_GET_BANK;
            end
          end
          P_GET_BANK: begin
            if (rx_byte_q == SOF) begin
              pay_q <= '0;
              cnt_q <= '0;
            end else if (rx_byte_q != EOF) begin
              pend_bank_q <= rx_byte_q - 8'h30;
              p_state_q   <= P_GET_DATA;
            end
          end
          P_GET_DATA: begin
            if (rx_byte_q == SOF) begin
              pay_q     <= '0;
              cnt_q     <= '0;
              p_state_q <= P_GET_BANK;
            end else if (rx_byte_q == EOF) begin
              data_out_q <= pay_q;
              bank_q     <= pend_bank_q;
              strobe_q   <= 1'b1;
              p_state_q  <= P_WAIT_SOF;
            end else if (cnt_q < 6'd32) begin
              pay_q <= {pay_q[247:0], rx_byte_q};
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: p_state_q <= P_WAIT_SOF;
        endcase
      end
    end
  end

  assign data_out        = data_out_q;
  assign bank            = bank_q;
  assign data_write_copy = strobe_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: serialises ASCII frames on rxd and
// checks strobe count, bank and payload against hand-computed values.
module tb_uart_rx_frame;

  localparam int CPB = 54;
  localparam int GAP = 30;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rxd = 1'b1;
  logic [255:0] data_out;
  logic         data_write_copy;
  logic [7:0]   bank;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int s0;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rxd(rxd),
    .data_out(data_out),
    .data_write_copy(data_write_copy),
    .bank(bank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_write_copy === 1'b1) strobe_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_lvl;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_data", data_out, 256'h0);
    chk("reset_bank", 256'(bank), 256'h0);
    chk("reset_strobe", 256'(data_write_copy), 256'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    s0 = strobe_cnt;
    send_str("<0120>");
    chk("f0120_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("f0120_bank", 256'(bank), 256'h00);
    chk("f0120_data", data_out, 256'h313230);

    s0 = strobe_cnt;
    send_str("<5AB>");
    chk("f5ab_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("f5ab_bank", 256'(bank), 256'h05);
    chk("f5ab_data", data_out, 256'h4142);

    s0 = strobe_cnt;
    send_str("<7>");
    chk("f7_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("f7_bank", 256'(bank), 256'h07);
    chk("f7_data", data_out, 256'h0);

    s0 = strobe_cnt;
    send_byte(8'h3C, 1'b0);
    send_str("0X>");
    chk("ferr_strobes", 256'(strobe_cnt - s0), 256'd0);
    chk("ferr_bank", 256'(bank), 256'h07);
    chk("ferr_data", data_out, 256'h0);

    s0 = strobe_cnt;
    send_str("<>8Q>");
    chk("eofbank_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("eofbank_bank", 256'(bank), 256'h08);
    chk("eofbank_data", data_out, 256'h51);

    s0 = strobe_cnt;
    send_str("<1AB<2C>");
    chk("restart_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("restart_bank", 256'(bank), 256'h02);
    chk("restart_data", data_out, 256'h43);

    @(negedge clk);
    rxd = 1'b0;
    repeat (11) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    s0 = strobe_cnt;
    send_str("<1Z>");
    chk("glitch_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("glitch_bank", 256'(bank), 256'h01);
    chk("glitch_data", data_out, 256'h5A);

    s0 = strobe_cnt;
    send_str("<0");
    for (int i = 0; i < 40; i++) send_byte(8'h41, 1'b1);
    send_byte(8'h3E, 1'b1);
    chk("long_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("long_bank", 256'(bank), 256'h00);
    chk("long_data", data_out, {32{8'h41}});

    send_str("<3");
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("rst_mid_data", data_out, 256'h0);
    chk("rst_mid_bank", 256'(bank), 256'h0);
    chk("rst_mid_strobe", 256'(data_write_copy), 256'h0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    s0 = strobe_cnt;
    send_str("AB>");
    chk("rst_tail_strobes", 256'(strobe_cnt - s0), 256'd0);
    chk("rst_tail_data", data_out, 256'h0);
    send_str("<9C>");
    chk("rst_fresh_strobes", 256'(strobe_cnt - s0), 256'd1);
    chk("rst_fresh_bank", 256'(bank), 256'h09);
    chk("rst_fresh_data", data_out, 256'h43);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter CLKS_PER_BIT, default 54, clock cycles per serial bit (>= 4).
REQ-002 Port clk  input  1  single system clock; all logic rising-edge.
REQ-003 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port rxd  input  1  asynchronous serial line, idle high.
REQ-005 Port data_out  output  256  last completed frame payload, 32 bytes.
REQ-006 Port data_write_copy  output  1  one-cycle strobe: data_out and bank updated.
REQ-007 Port bank  output  8  bank number of last completed frame.

Function
REQ-008 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-009 Byte receiver states IDLE, START, DATA, STOP.
- Format: 8N1, LSB first.
REQ-010 IDLE -> START on a synchronized high-to-low transition of rxd.
REQ-011 START SHALL re-sample rxd at CLKS_PER_BIT/2.
- Low: go to DATA.
- High: glitch; return to IDLE, no byte delivered.
REQ-012 DATA SHALL sample 8 bits, each CLKS_PER_BIT after the previous sample (bit centres).
REQ-013 STOP SHALL sample rxd one bit period after bit 7.
- High: deliver the byte as a one-cycle internal valid.
- Low: framing error; drop the byte, abort any open frame, return to IDLE.
REQ-014 After the stop sample, the receiver SHALL return to IDLE and accept a new start edge immediately.
REQ-015 Frame parser states WAIT_SOF, GET_BANK, GET_DATA.
REQ-016 WAIT_SOF: byte 0x3C ('<') -> GET_BANK and clear payload buffer and byte count; any other byte ignored.
REQ-017 GET_BANK: next byte B latched as pending bank = (B - 0x30) mod 256 -> GET_DATA.
- B = 0x3C restarts the frame instead.
REQ-018 GET_DATA: each byte other than 0x3C/0x3E is shifted in: buffer <= {buffer[247:0], byte}; count increments.
- Bytes after 32 stored bytes are discarded.
REQ-019 GET_DATA: 0x3E ('>') SHALL end the frame on the cycle after the byte is delivered:
- data_out <= buffer;
- bank <= pending bank;
- data_write_copy high for exactly one cycle;
- -> WAIT_SOF.
REQ-020 0x3C received in GET_DATA SHALL restart the frame: clear buffer, -> GET_BANK.
REQ-021 0x3E received in WAIT_SOF or GET_BANK SHALL be ignored; in GET_BANK, remain in GET_BANK.
REQ-022 A frame with zero payload bytes SHALL still complete, with data_out = 0.
REQ-023 data_out and bank SHALL hold their values between completed frames; partial frames never alter them.

Reset
REQ-024 reset_n low SHALL immediately force:
- data_out = 0, bank = 0, data_write_copy = 0;
- both state machines idle (IDLE, WAIT_SOF);
- buffer, count and pending bank = 0;
- synchronizer flops = 1.
REQ-025 Reset asserted mid-byte or mid-frame SHALL discard all partial data; reception resumes at the next start edge after release.

Verification
REQ-026 Bytes "<0120>" (0x3C 0x30 0x31 0x32 0x30 0x3E) at 54 clk/bit, idle between bytes -> exactly one strobe; bank = 0x00; data_out = 0x313230 (upper 232 bits 0).
REQ-027 "<5AB>" then "<7>" -> first strobe: bank 0x05, data_out 0x4142; second strobe: bank 0x07, data_out 0.
REQ-028 0x3C sent with stop bit forced low, then "0X>" -> no strobe; outputs keep previous values.
REQ-029 0.2-bit low glitch on idle rxd, then a valid frame "<1Z>" -> no spurious byte; bank 0x01, data_out 0x5A.
REQ-030 "<0" followed by 40 bytes 0x41 and '>' -> data_out = 32 x 0x41; strobe once.
REQ-031 reset_n pulsed low during byte 3 of a frame -> outputs 0 at once; no strobe until a fresh complete frame arrives.
